// File: rtl/kcore_wb_pkg.sv
// Shared types and helpers for the k-core write-back stage.
package kcore_wb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_AW    = 2'd1,
    S_W     = 2'd2,
    S_DRAIN = 2'd3
  } wb_state_e;

  localparam int AWLEN_W = 8;

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/kcore_wb_outstanding_ctr.sv
// Saturating up/down counter of write bursts awaiting a B response.
module kcore_wb_outstanding_ctr #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;
  logic         inc_eff, dec_eff;

  assign zero  = (count_q == '0);
  assign full  = (count_q == W'(MAX));
  assign count = count_q;

  // A response with nothing outstanding is dropped; an issue at MAX only lands if a response frees a slot
  always_comb begin
    dec_eff = dec & ~zero;
    inc_eff = inc & (~full | dec_eff);
    count_d = count_q;
    if (inc_eff && !dec_eff) begin
      count_d = count_q + W'(1);
    end else if (dec_eff && !inc_eff) begin
      count_d = count_q - W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/kcore_write_back_stage.sv
// k-core write-back stage: pops a start token, drains the core-value FIFO as
// AXI4-style write bursts and pulses done once every burst is acknowledged.
// Optional: define KCORE_WB_ERR_EN to add m_bresp input and sticky err output.
module kcore_write_back_stage
  import kcore_wb_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int CNT_WIDTH       = 16,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_empty_n,
  output logic                  start_read,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_words,
  input  logic                  din_empty_n,
  output logic                  din_read,
  input  logic [DATA_WIDTH-1:0] din_dout,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic [AWLEN_W-1:0]    m_awlen,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic                  m_wlast,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic                  done,
  output logic                  idle
`ifdef KCORE_WB_ERR_EN
  ,
  input  logic [1:0]            m_bresp,
  output logic                  err
`endif
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDR_WIDTH-1:0] WORD_BYTES  = ADDR_WIDTH'(bytes_per_word(DATA_WIDTH));
  localparam logic [CNT_WIDTH-1:0]  MAX_BURST_C = CNT_WIDTH'(MAX_BURST);

  wb_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
  logic [CNT_WIDTH-1:0]  beat_q, beat_d;
  logic                  done_q, done_d;

  logic [CNT_WIDTH-1:0]  blen;
  logic                  aw_hs;
  logic                  w_hs;
  logic [OUT_W-1:0]      out_count;
  logic                  out_full;
  logic                  out_zero;

  kcore_wb_outstanding_ctr #(
    .MAX (MAX_OUTSTANDING),
    .W   (OUT_W)
  ) u_outstanding (
    .clk   (clk),
    .reset (reset),
    .inc   (aw_hs),
    .dec   (m_bvalid),
    .count (out_count),
    .full  (out_full),
    .zero  (out_zero)
  );

  assign m_bready = 1'b1;
  assign idle     = (state_q == S_IDLE);
  assign done     = done_q;

  // Interface outputs decoded from the current state; wvalid never looks at wready
  always_comb begin
    blen       = (remaining_q > MAX_BURST_C) ? MAX_BURST_C : remaining_q;
    start_read = (state_q == S_IDLE) & start_empty_n;
    m_awvalid  = (state_q == S_AW) & ~out_full;
    m_awaddr   = addr_q;
    m_awlen    = (state_q == S_AW) ? (blen[AWLEN_W-1:0] - AWLEN_W'(1)) : '0;
    m_wvalid   = (state_q == S_W) & din_empty_n;
    m_wdata    = (state_q == S_W) ? din_dout : '0;
    m_wlast    = (state_q == S_W) && (beat_q == CNT_WIDTH'(1));
    din_read   = m_wvalid & m_wready;
    aw_hs      = m_awvalid & m_awready;
    w_hs       = din_read;
  end

  // Next-state logic; the address advances one word per accepted beat, so it
  // has moved by a whole burst when the last beat lands
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    beat_d      = beat_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_empty_n) begin
          addr_d      = base_addr;
          remaining_d = num_words;
          state_d     = (num_words == '0) ? S_DRAIN : S_AW;
        end
      end
      S_AW: begin
        if (aw_hs) begin
          beat_d  = blen;
          state_d = S_W;
        end
      end
      S_W: begin
        if (w_hs) begin
          beat_d      = beat_q - CNT_WIDTH'(1);
          remaining_d = remaining_q - CNT_WIDTH'(1);
          addr_d      = addr_q + WORD_BYTES;
          if (beat_q == CNT_WIDTH'(1)) begin
            state_d = (remaining_q == CNT_WIDTH'(1)) ? S_DRAIN : S_AW;
          end
        end
      end
      S_DRAIN: begin
        // done is registered, so look at the count as it will be after this cycle's response
        if (out_zero || ((out_count == OUT_W'(1)) && m_bvalid)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      beat_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      beat_q      <= beat_d;
      done_q      <= done_d;
    end
  end

`ifdef KCORE_WB_ERR_EN
  logic err_q, err_d;
  logic unused_bresp0;

  assign unused_bresp0 = m_bresp[0];
  assign err           = err_q;

  // Sticky slave/decode error flag, cleared when the next run is accepted
  always_comb begin
    err_d = err_q;
    if (start_read) begin
      err_d = 1'b0;
    end
    if (m_bvalid && m_bresp[1]) begin
      err_d = 1'b1;
    end
  end

  // Error flag register
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_kcore_write_back_stage.sv
// Self-checking bench for kcore_write_back_stage.
module tb_kcore_write_back_stage;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int CW = 16;
  localparam int MB = 16;
  localparam int MO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_empty_n;
  logic          start_read;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] num_words;
  logic          din_empty_n;
  logic          din_read;
  logic [DW-1:0] din_dout;
  logic          m_awvalid;
  logic          m_awready;
  logic [AW-1:0] m_awaddr;
  logic [7:0]    m_awlen;
  logic          m_wvalid;
  logic          m_wready;
  logic [DW-1:0] m_wdata;
  logic          m_wlast;
  logic          m_bvalid;
  logic          m_bready;
  logic          done;
  logic          idle;
`ifdef KCORE_WB_ERR_EN
  logic [1:0]    m_bresp;
  logic          err;
`endif

  always #5 clk = ~clk;

  kcore_write_back_stage dut (
    .clk           (clk),
    .reset         (reset),
    .start_empty_n (start_empty_n),
    .start_read    (start_read),
    .base_addr     (base_addr),
    .num_words     (num_words),
    .din_empty_n   (din_empty_n),
    .din_read      (din_read),
    .din_dout      (din_dout),
    .m_awvalid     (m_awvalid),
    .m_awready     (m_awready),
    .m_awaddr      (m_awaddr),
    .m_awlen       (m_awlen),
    .m_wvalid      (m_wvalid),
    .m_wready      (m_wready),
    .m_wdata       (m_wdata),
    .m_wlast       (m_wlast),
    .m_bvalid      (m_bvalid),
    .m_bready      (m_bready),
    .done          (done),
    .idle          (idle)
`ifdef KCORE_WB_ERR_EN
    ,
    .m_bresp       (m_bresp),
    .err           (err)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- environment (stimulus side) ----------------
  logic [DW-1:0] data_q[$];
  logic [DW-1:0] run_words[$];
  logic [AW-1:0] tok_base;
  int            tok_n;
  bit            tok_avail = 0;
  bit            din_stall = 0;
  bit            rand_mode = 0;
  bit            b_hold    = 0;
  int            b_release = 0;
  int            pend_b    = 0;
  bit            err_inject = 0;

  task automatic drive_fifo();
    start_empty_n = tok_avail;
    base_addr     = tok_base;
    num_words     = CW'(tok_n);
    din_empty_n   = (data_q.size() > 0) && !din_stall;
    din_dout      = (data_q.size() > 0) ? data_q[0] : '0;
  endtask

  // One clock of the FIFO/memory environment; returns at posedge + 1
  task automatic step();
    bit pop_d, pop_t, wl;
    @(negedge clk);
    pop_d = din_read;
    pop_t = start_read;
    wl    = m_wvalid & m_wready & m_wlast;
    @(posedge clk);
    #1;
    m_bvalid = 1'b0;
`ifdef KCORE_WB_ERR_EN
    m_bresp = 2'b00;
`endif
    if (reset) begin
      data_q.delete();
      pend_b    = 0;
      tok_avail = 0;
    end else begin
      if (pop_d && data_q.size() > 0) void'(data_q.pop_front());
      if (pop_t) tok_avail = 0;
      if (wl) pend_b++;
      if (pend_b > 0 && (!b_hold || b_release > 0) && (!rand_mode || $urandom_range(0, 1) == 1)) begin
        m_bvalid = 1'b1;
        pend_b--;
        if (b_hold) b_release--;
`ifdef KCORE_WB_ERR_EN
        if (err_inject) begin
          m_bresp    = 2'b10;
          err_inject = 0;
        end
`endif
      end
    end
    if (rand_mode) begin
      m_wready  = 1'($urandom_range(0, 1));
      m_awready = 1'($urandom_range(0, 1));
      din_stall = ($urandom_range(0, 3) == 0);
    end else begin
      m_wready  = 1'b1;
      m_awready = 1'b1;
      din_stall = 0;
    end
    drive_fifo();
  endtask

  task automatic start_run(input logic [AW-1:0] base, input int n);
    logic [DW-1:0] w;
    run_words.delete();
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      run_words.push_back(w);
      data_q.push_back(w);
    end
    tok_base  = base;
    tok_n     = n;
    tok_avail = 1;
    drive_fifo();
  endtask

  // ---------------- reference model + compare process ----------------
  int            cyc = 0;
  logic [AW-1:0] exp_addr[$];
  int            exp_len[$];
  logic [DW-1:0] exp_w[$];
  int            lens_q[$];
  int            beat_idx = 0;
  int            model_out = 0;
  int            done_total = 0;
  int            done_cyc = 0, pop_cyc = 0, last_b_cyc = 0, first_aw_cyc = -1;
  int            run_aw = 0, run_w = 0, run_wlast = 0, run_b = 0;
  logic [AW-1:0] run_aw_addr[$];
  int            run_aw_len[$];
  bit            prev_aw_wait = 0;
  logic [AW-1:0] prev_awaddr;
  logic [7:0]    prev_awlen;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      exp_addr.delete();
      exp_len.delete();
      exp_w.delete();
      lens_q.delete();
      beat_idx     = 0;
      model_out    = 0;
      prev_aw_wait = 0;
    end else begin
      if (start_read) begin
        pop_cyc = cyc;
        first_aw_cyc = -1;
        run_aw = 0; run_w = 0; run_wlast = 0; run_b = 0;
        run_aw_addr.delete();
        run_aw_len.delete();
        for (int off = 0; off < tok_n; off += MB) begin
          exp_addr.push_back(tok_base + off * (DW / 8));
          exp_len.push_back((((tok_n - off) > MB) ? MB : (tok_n - off)) - 1);
        end
        foreach (run_words[i]) exp_w.push_back(run_words[i]);
      end

      if (done) begin
        done_total++;
        done_cyc = cyc;
        chk("done_all_acked",
            (exp_w.size() == 0 && exp_addr.size() == 0 && lens_q.size() == 0 && model_out == 0), 1);
      end

      if (prev_aw_wait) chk("aw_stable", {m_awvalid, m_awaddr, m_awlen}, {1'b1, prev_awaddr, prev_awlen});
      prev_aw_wait = m_awvalid & ~m_awready;
      prev_awaddr  = m_awaddr;
      prev_awlen   = m_awlen;

      chk("wvalid_no_data", m_wvalid & ~din_empty_n, 0);
      chk("din_read_hs", din_read, m_wvalid & m_wready);

      if (m_wvalid && m_wready) begin
        run_w++;
        if (lens_q.size() == 0 || exp_w.size() == 0) begin
          chk("w_unexpected", 1, 0);
        end else begin
          chk("wdata", m_wdata, exp_w.pop_front());
          chk("wlast", m_wlast, beat_idx == lens_q[0]);
          if (beat_idx == lens_q[0]) begin
            void'(lens_q.pop_front());
            beat_idx = 0;
            run_wlast++;
          end else begin
            beat_idx++;
          end
        end
      end

      if (m_awvalid && m_awready) begin
        run_aw++;
        if (first_aw_cyc < 0) first_aw_cyc = cyc;
        run_aw_addr.push_back(m_awaddr);
        run_aw_len.push_back(int'(m_awlen));
        chk("aw_window", model_out < MO, 1);
        if (exp_addr.size() == 0) begin
          chk("aw_unexpected", 1, 0);
        end else begin
          chk("awaddr", m_awaddr, exp_addr.pop_front());
          chk("awlen", m_awlen, exp_len[0]);
          lens_q.push_back(exp_len.pop_front());
        end
      end

      if (m_bvalid) begin
        run_b++;
        last_b_cyc = cyc;
        if (model_out > 0) model_out--;
      end
      if (m_awvalid && m_awready) model_out++;
    end
  end

  task automatic wait_done(input int max, input string name);
    int d0;
    d0 = done_total;
    for (int i = 0; i < max && done_total == d0; i++) step();
    chk({name, "_done_seen"}, done_total != d0, 1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    reset = 1'b1; start_empty_n = 1'b0; base_addr = '0; num_words = '0;
    din_empty_n = 1'b0; din_dout = '0; m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0;
    tok_base = '0; tok_n = 0;
`ifdef KCORE_WB_ERR_EN
    m_bresp = 2'b00;
`endif
    repeat (3) step();
    reset = 1'b0;
    chk("rst_awvalid", m_awvalid, 0);
    chk("rst_wvalid", m_wvalid, 0);
    chk("rst_start_read", start_read, 0);
    chk("rst_din_read", din_read, 0);
    chk("rst_done", done, 0);
    chk("rst_wlast", m_wlast, 0);
    chk("rst_awlen", m_awlen, 0);
    chk("rst_bready", m_bready, 1);
    chk("rst_idle", idle, 1);
`ifdef KCORE_WB_ERR_EN
    chk("rst_err", err, 0);
`endif
    step();

    // 1: single short burst
    start_run(32'h1000, 5);
    wait_done(100, "t1");
    chk("t1_aw_count", run_aw, 1);
    chk("t1_awaddr", run_aw_addr.size() > 0 ? run_aw_addr[0] : 'x, 32'h1000);
    chk("t1_awlen", run_aw_len.size() > 0 ? run_aw_len[0] : -1, 4);
    chk("t1_beats", run_w, 5);
    chk("t1_wlast_count", run_wlast, 1);
    chk("t1_pop_to_aw", first_aw_cyc - pop_cyc, 1);
    chk("t1_b_to_done", done_cyc - last_b_cyc, 1);
    chk("t1_idle_after", idle, 1);
    step();

    // 2: three bursts, last one short
    err_inject = 1;
    start_run(32'h1000, 40);
    wait_done(300, "t2");
    chk("t2_aw_count", run_aw, 3);
    chk("t2_aw1", run_aw_addr.size() > 1 ? run_aw_addr[1] : 'x, 32'h1040);
    chk("t2_aw2", run_aw_addr.size() > 2 ? run_aw_addr[2] : 'x, 32'h1080);
    chk("t2_len1", run_aw_len.size() > 1 ? run_aw_len[1] : -1, 15);
    chk("t2_len2", run_aw_len.size() > 2 ? run_aw_len[2] : -1, 7);
    chk("t2_b_count", run_b, 3);
    chk("t2_b_to_done", done_cyc - last_b_cyc, 1);
`ifdef KCORE_WB_ERR_EN
    chk("t2_err_set", err, 1);
`endif
    step();

    // 3: empty run
    start_run(32'h2000, 0);
    wait_done(20, "t3");
    chk("t3_pop_to_done", done_cyc - pop_cyc, 2);
    chk("t3_aw_count", run_aw, 0);
    chk("t3_beats", run_w, 0);
`ifdef KCORE_WB_ERR_EN
    chk("t3_err_cleared", err, 0);
`endif
    step();

    // 4: responses withheld, outstanding limit
    b_hold = 1; b_release = 0;
    start_run(32'h4000, 96);
    repeat (200) step();
    chk("t4_aw_capped", run_aw, 4);
    chk("t4_wlast_count", run_wlast, 4);
    chk("t4_awvalid_low", m_awvalid, 0);
    chk("t4_not_done", done_total, 3);
    b_release = 1;
    for (int i = 0; i < 20 && run_aw < 5; i++) step();
    chk("t4_fifth_aw", run_aw, 5);
    b_hold = 0;
    wait_done(400, "t4");
    chk("t4_aw_total", run_aw, 6);
    step();

    // 5: random stalls on every handshake
    rand_mode = 1;
    start_run(32'h8000, 37);
    wait_done(2000, "t5");
    rand_mode = 0;
    step();
    chk("t5_beats", run_w, 37);
    chk("t5_aw_count", run_aw, 3);

    // 6: reset mid-burst, then a clean run
    err_inject = 1;
    start_run(32'h1000, 40);
    for (int i = 0; i < 100 && run_w < 20; i++) step();
    chk("t6_mid_burst", run_w >= 20, 1);
`ifdef KCORE_WB_ERR_EN
    chk("t6_err_set", err, 1);
`endif
    reset = 1'b1;
    step();
    chk("t6_rst_awvalid", m_awvalid, 0);
    chk("t6_rst_wvalid", m_wvalid, 0);
    chk("t6_rst_din_read", din_read, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_idle", idle, 1);
`ifdef KCORE_WB_ERR_EN
    chk("t6_rst_err", err, 0);
`endif
    reset = 1'b0;
    step();
    start_run(32'h3000, 3);
    wait_done(60, "t6");
    chk("t6_beats", run_w, 3);
    chk("t6_awaddr", run_aw_addr.size() > 0 ? run_aw_addr[0] : 'x, 32'h3000);
    chk("t6_awlen", run_aw_len.size() > 0 ? run_aw_len[0] : -1, 2);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kcore_write_back_stage.md
Name: kcore_write_back_stage

Overview:
Dataflow write-back process of the k-core kernel; the consumer stage of the 1-bit start-token FIFO that sits in front of it.
- Pops one start token per run and samples the run arguments (base address, word count).
- Drains a data-stream FIFO of core values.
- Issues them as AXI4-style write bursts to memory, tracking outstanding responses.
- Pulses done once every write is acknowledged.

Parameters:
DATA_WIDTH, 32, width of one core-value word and of m_wdata
ADDR_WIDTH, 32, byte-address width
CNT_WIDTH, 16, width of num_words and internal word counters
MAX_BURST, 16, max beats per burst (power of two, MAX_BURST*DATA_WIDTH/8 <= 4096)
MAX_OUTSTANDING, 4, max bursts issued without B response

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start_empty_n  in  1  start FIFO has token
start_read  out  1  pop start token
base_addr  in  ADDR_WIDTH  run base byte address, sampled on token pop
num_words  in  CNT_WIDTH  words in run, sampled on token pop
din_empty_n  in  1  data FIFO non-empty
din_read  out  1  pop data FIFO
din_dout  in  DATA_WIDTH  data FIFO head (combinational)
m_awvalid  out  1  write-address valid
m_awready  in  1  write-address ready
m_awaddr  out  ADDR_WIDTH  burst start byte address
m_awlen  out  8  beats minus one
m_wvalid  out  1  write-data valid
m_wready  in  1  write-data ready
m_wdata  out  DATA_WIDTH  write data
m_wlast  out  1  last beat of burst
m_bvalid  in  1  write response valid
m_bready  out  1  response ready (constant 1)
done  out  1  one-cycle pulse, run complete
idle  out  1  high in S_IDLE

Behaviour:
Reset:
- All outputs 0 except m_bready=1 and idle=1.
- State S_IDLE; counters cleared.
- A reset mid-run abandons the run without draining; the memory side is reset together with this block.

States and transitions:
- S_IDLE: start_read = start_empty_n. On pop, latch base_addr into addr_r and num_words into remaining_r, then go to S_AW. If num_words==0, go to S_DRAIN instead.
- S_AW: m_awvalid=1, m_awaddr=addr_r, m_awlen=blen-1, where blen=min(remaining_r, MAX_BURST).
  - Enter only when outstanding < MAX_OUTSTANDING; otherwise hold in S_AW with awvalid low.
  - On awvalid&awready: beat_r=blen, outstanding+1, go to S_W.
- S_W: m_wvalid = din_empty_n; m_wdata = din_dout; din_read = din_empty_n & m_wready; m_wlast = (beat_r==1).
  - Each accepted beat decrements beat_r and remaining_r.
  - On the last beat, addr_r += blen*DATA_WIDTH/8. Then go to S_AW if remaining_r>0 after the beat, else S_DRAIN.
- S_DRAIN: wait for outstanding==0, then done=1 for one cycle and return to S_IDLE.

Response tracking:
- In every state, m_bvalid decrements outstanding.
- Simultaneous AW handshake and B response: outstanding is unchanged.
- Outstanding never exceeds MAX_OUTSTANDING and never underflows; a B with outstanding==0 is ignored.

Handshake rules:
- AW is always issued before its W beats; one burst is in W at a time.
- m_awaddr and m_awlen are held stable while awvalid is high and not accepted.
- m_wvalid must not depend on m_wready.

Address and width rules:
- base_addr is aligned to MAX_BURST*DATA_WIDTH/8, so no burst crosses 4 KB.
- addr_r wraps modulo 2^ADDR_WIDTH.
- Last burst is short when num_words % MAX_BURST != 0.

Latency and throughput:
- Token pop to first awvalid: 1 cycle.
- Full throughput: 1 beat/cycle, plus 1 AW cycle per burst.
- Start tokens are not popped outside S_IDLE.

Optional Feature:
KCORE_WB_ERR_EN:
- Defined: adds input m_bresp[1:0] and output err (reset 0).
- err is sticky-set when m_bvalid & m_bresp[1]; it clears only on reset or on the next token pop.
- The run still completes normally.
- Undefined: no m_bresp or err ports; responses are counted only.

Decomposition:
- Package kcore_wb_pkg: state enum (S_IDLE, S_AW, S_W, S_DRAIN), AWLEN width constant 8, bytes-per-word function.
- Sub-module kcore_wb_outstanding_ctr: saturating up/down counter with inc, dec, count, full and zero outputs.

Test Plan:
1. base=0x1000, num_words=5, FIFO holds 5 words, always ready -> one AW (addr 0x1000, len 4), 5 beats with wlast on the 5th, one B, done pulses 1 cycle after the B.
2. num_words=40, MAX_BURST=16 -> AWs at 0x1000/0x1040/0x1080 with len 15/15/7; done only after the 3rd B.
3. num_words=0 -> token popped, no AW or W activity, done 2 cycles after pop.
4. B responses withheld, num_words=96 (6 bursts) -> exactly 4 AWs issued and awvalid stays low; releasing one B allows the 5th AW.
5. Random m_wready/din_empty_n stalls -> wdata sequence matches FIFO order; wvalid never high while the FIFO is empty; din_read only when wvalid&wready.
6. Reset asserted mid-burst -> next cycle all valids 0, idle=1; a following token runs cleanly. Under KCORE_WB_ERR_EN, a bresp=2'b10 on run 1 sets err, and err clears on the next token pop.
